// File: rtl/syn_exec_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syn_exec_controller_pkg
// Description : Shared types for the run/step/halt sequencer: FSM state
//               encodings and the operator-button priority decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package syn_exec_controller_pkg;

    // Width of the exported state field
    localparam int EXEC_ST_BIT = 3;

    // Sequencer states; the numeric values are visible on the state port
    typedef enum logic [EXEC_ST_BIT-1:0] {
        EXEC_ST_STOP = 3'd0,
        EXEC_ST_RUN  = 3'd1,
        EXEC_ST_STEP = 3'd2,
        EXEC_ST_KICK = 3'd3,
        EXEC_ST_HALT = 3'd4
    } exec_state_e;

    // Resolved operator command after priority arbitration
    typedef enum logic [1:0] {
        EXEC_CMD_NONE  = 2'd0,
        EXEC_CMD_RUN   = 2'd1,
        EXEC_CMD_STEP  = 2'd2,
        EXEC_CMD_PAUSE = 2'd3
    } exec_cmd_e;

    // Simultaneous button pulses resolve as pause > step > run
    function automatic exec_cmd_e f_decode_cmd(
        input logic run,
        input logic step,
        input logic pause
    );
        exec_cmd_e cmd;
        if (pause) begin
            cmd = EXEC_CMD_PAUSE;
        end else if (step) begin
            cmd = EXEC_CMD_STEP;
        end else if (run) begin
            cmd = EXEC_CMD_RUN;
        end else begin
            cmd = EXEC_CMD_NONE;
        end
        return cmd;
    endfunction

endpackage : syn_exec_controller_pkg
`default_nettype wire

// File: rtl/exec_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : exec_event_counter
// Description : Wrapping event counter with synchronous clear. Clear wins
//               over a same-cycle increment.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_event_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,   // active-high synchronous reset
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Count enabled events; wraps naturally at 2^CNT_WIDTH
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign cnt = r_cnt;

endmodule : exec_event_counter
`default_nettype wire

// File: rtl/syn_exec_controller.sv
`default_nettype none
// ============================================================================
// Module      : syn_exec_controller
// Description : Run/step/halt sequencer for the single-cycle core. Produces
//               the core enable from operator buttons, a rate prescaler and
//               the syscall halt level, and keeps per-instruction statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_exec_controller
    import syn_exec_controller_pkg::*;
#(
    parameter int DIV_WIDTH = 24,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,      // active-high synchronous reset
    input  logic                 btn_run,
    input  logic                 btn_step,
    input  logic                 btn_pause,
    input  logic [DIV_WIDTH-1:0] div_sel,
    input  logic                 halt,
    input  logic                 is_jump,
    input  logic                 is_branch,
    input  logic                 branched,
    input  logic                 cnt_clr,
    output logic                 cpu_en,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cnt_cycle,
    output logic [CNT_WIDTH-1:0] cnt_jump,
    output logic [CNT_WIDTH-1:0] cnt_branch,
    output logic [CNT_WIDTH-1:0] cnt_taken
);

    exec_state_e          r_state;
    logic [DIV_WIDTH-1:0] r_presc;
    logic                 w_presc_hit;
    logic                 w_cpu_en;
    exec_cmd_e            w_cmd;
    logic [3:0]           w_inc;
    logic [CNT_WIDTH-1:0] w_cnt [4];

    // ">=" rather than "==" so that lowering div_sel below the running count
    // fires on the next cycle instead of waiting for the prescaler to wrap.
    assign w_presc_hit = (r_presc >= div_sel);
    assign w_cmd       = f_decode_cmd(btn_run, btn_step, btn_pause);

    // Enable decode is combinational on halt so that a halt raised by the
    // instruction just committed blocks the very next enable.
    always_comb begin
        w_cpu_en = 1'b0;
        case (r_state)
            EXEC_ST_RUN:  w_cpu_en = w_presc_hit && !halt;
            EXEC_ST_STEP: w_cpu_en = 1'b1;   // steps past a pending syscall halt
            EXEC_ST_KICK: w_cpu_en = 1'b1;   // resumes past a pending syscall halt
            default:      w_cpu_en = 1'b0;
        endcase
    end

    // Sequencer FSM and prescaler; presc restarts from zero on every RUN entry
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= EXEC_ST_STOP;
            r_presc <= '0;
        end else begin
            case (r_state)
                EXEC_ST_STOP: begin
                    r_presc <= '0;
                    if (btn_step) begin
                        r_state <= EXEC_ST_STEP;
                    end else if (btn_run) begin
                        r_state <= EXEC_ST_RUN;
                    end
                end
                EXEC_ST_RUN: begin
                    if (w_cpu_en) begin
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + DIV_WIDTH'(1);
                    end
                    // step/run pulses carry no meaning while already running
                    if (w_cmd == EXEC_CMD_PAUSE) begin
                        r_state <= EXEC_ST_STOP;
                    end else if (halt) begin
                        r_state <= EXEC_ST_HALT;
                    end
                end
                EXEC_ST_STEP: begin
                    r_presc <= '0;
                    r_state <= EXEC_ST_STOP;
                end
                EXEC_ST_KICK: begin
                    r_presc <= '0;
                    r_state <= EXEC_ST_RUN;
                end
                EXEC_ST_HALT: begin
                    r_presc <= '0;
                    case (w_cmd)
                        EXEC_CMD_PAUSE: r_state <= EXEC_ST_STOP;
                        EXEC_CMD_STEP:  r_state <= EXEC_ST_STEP;
                        EXEC_CMD_RUN:   r_state <= EXEC_ST_KICK;
                        default:        r_state <= EXEC_ST_HALT;
                    endcase
                end
                default: begin
                    r_presc <= '0;
                    r_state <= EXEC_ST_STOP;
                end
            endcase
        end
    end

    // Per-counter increment qualifiers: cycle, jump, branch, taken
    assign w_inc = {w_cpu_en & branched,
                    w_cpu_en & is_branch,
                    w_cpu_en & is_jump,
                    w_cpu_en};

    for (genvar gi = 0; gi < 4; gi++) begin : g_counters
        exec_event_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (cnt_clr),
            .inc   (w_inc[gi]),
            .cnt   (w_cnt[gi])
        );
    end

    assign cpu_en     = w_cpu_en;
    assign state      = r_state;
    assign cnt_cycle  = w_cnt[0];
    assign cnt_jump   = w_cnt[1];
    assign cnt_branch = w_cnt[2];
    assign cnt_taken  = w_cnt[3];

endmodule : syn_exec_controller
`default_nettype wire

// File: tb/tb_syn_exec_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_syn_exec_controller
// Description : Self-checking bench for syn_exec_controller. A table of
//               per-cycle vectors with hand-derived expectations, backed by a
//               cycle model whose predictions flow through a scoreboard queue.
//               A second instance with 4-bit counters covers wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syn_exec_controller;

    localparam int DW = 24;
    localparam int CW = 32;

    localparam bit [2:0] B_RUN   = 3'b001;
    localparam bit [2:0] B_STEP  = 3'b010;
    localparam bit [2:0] B_PAUSE = 3'b100;

    logic          clk = 1'b0;
    logic          rst_n, btn_run, btn_step, btn_pause, halt;
    logic          is_jump, is_branch, branched, cnt_clr;
    logic [DW-1:0] div_sel;
    logic          cpu_en, cpu_en4;
    logic [2:0]    state, state4;
    logic [CW-1:0] cnt_cycle, cnt_jump, cnt_branch, cnt_taken;
    logic [3:0]    n_cycle, n_jump, n_branch, n_taken;

    always #5 clk = ~clk;

    syn_exec_controller #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .btn_pause(btn_pause), .div_sel(div_sel), .halt(halt),
        .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
        .cnt_clr(cnt_clr), .cpu_en(cpu_en), .state(state),
        .cnt_cycle(cnt_cycle), .cnt_jump(cnt_jump),
        .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
    );

    syn_exec_controller #(.DIV_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .btn_pause(btn_pause), .div_sel(div_sel), .halt(halt),
        .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
        .cnt_clr(cnt_clr), .cpu_en(cpu_en4), .state(state4),
        .cnt_cycle(n_cycle), .cnt_jump(n_jump),
        .cnt_branch(n_branch), .cnt_taken(n_taken)
    );

    // One cycle of stimulus plus optional hand expectations (-1 = no check)
    typedef struct {
        bit [2:0] cmd;    // {pause, step, run}
        bit       hlt;
        int       div;
        bit [2:0] jbt;    // {is_jump, is_branch, branched}
        bit       clr;
        bit       rst;
        bit       skip;
        bit       hchk;
        bit       hen;
        bit [2:0] hst;
        int       hc, hj, hb, ht;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic        men;
        logic [2:0]  mst;
        logic [31:0] mc, mj, mb, mt;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    logic [2:0]    m_st    = 3'd0;
    logic [DW-1:0] m_presc = '0;
    logic [31:0]   m_c = 0, m_j = 0, m_b = 0, m_t = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit [2:0] cmd, input bit hlt, input int div,
                       input bit [2:0] jbt, input bit clr, input bit rst,
                       input bit hen, input bit [2:0] hst);
        vec_t v;
        v.cmd = cmd; v.hlt = hlt; v.div = div; v.jbt = jbt; v.clr = clr;
        v.rst = rst; v.skip = 1'b0; v.hchk = 1'b1; v.hen = hen; v.hst = hst;
        v.hc = -1; v.hj = -1; v.hb = -1; v.ht = -1;
        tbl.push_back(v);
    endtask

    task automatic addc(input int c, input int j, input int b, input int t);
        tbl[tbl.size()-1].hc = c;
        tbl[tbl.size()-1].hj = j;
        tbl[tbl.size()-1].hb = b;
        tbl[tbl.size()-1].ht = t;
    endtask

    // Drive one cycle, predict its outputs, queue the prediction, advance model
    task automatic apply(input vec_t v);
        sb_t      e;
        logic [2:0] nxt;
        @(posedge clk);
        #1;
        {btn_pause, btn_step, btn_run} = v.cmd;
        {is_jump, is_branch, branched} = v.jbt;
        halt    = v.hlt;
        div_sel = v.div[DW-1:0];
        cnt_clr = v.clr;
        rst_n   = v.rst;

        e.v   = v;
        e.mst = m_st;
        e.mc  = m_c; e.mj = m_j; e.mb = m_b; e.mt = m_t;
        if (m_st == 3'd1)                      e.men = (m_presc >= div_sel) && !v.hlt;
        else if (m_st == 3'd2 || m_st == 3'd3) e.men = 1'b1;
        else                                   e.men = 1'b0;
        sbq.push_back(e);

        if (v.rst) begin
            m_st = 3'd0; m_presc = '0;
            m_c = 0; m_j = 0; m_b = 0; m_t = 0;
        end else begin
            if (v.clr) begin
                m_c = 0; m_j = 0; m_b = 0; m_t = 0;
            end else if (e.men) begin
                m_c = m_c + 1;
                m_j = m_j + {31'd0, v.jbt[2]};
                m_b = m_b + {31'd0, v.jbt[1]};
                m_t = m_t + {31'd0, v.jbt[0]};
            end
            nxt = m_st;
            if (m_st == 3'd0) begin
                if (v.cmd[1])      nxt = 3'd2;
                else if (v.cmd[0]) nxt = 3'd1;
                m_presc = '0;
            end else if (m_st == 3'd1) begin
                m_presc = e.men ? '0 : m_presc + 1'b1;
                if (v.cmd[2])   nxt = 3'd0;
                else if (v.hlt) nxt = 3'd4;
            end else if (m_st == 3'd2) begin
                nxt = 3'd0; m_presc = '0;
            end else if (m_st == 3'd3) begin
                nxt = 3'd1; m_presc = '0;
            end else begin
                if (v.cmd[2])      nxt = 3'd0;
                else if (v.cmd[1]) nxt = 3'd2;
                else if (v.cmd[0]) nxt = 3'd3;
                m_presc = '0;
            end
            m_st = nxt;
        end
    endtask

    // Pop one prediction per cycle and compare on the falling edge
    always @(negedge clk) begin
        sb_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (!e.v.skip) begin
                chk("cpu_en",     32'(cpu_en),    32'(e.men));
                chk("state",      32'(state),     32'(e.mst));
                chk("cnt_cycle",  cnt_cycle,      e.mc);
                chk("cnt_jump",   cnt_jump,       e.mj);
                chk("cnt_branch", cnt_branch,     e.mb);
                chk("cnt_taken",  cnt_taken,      e.mt);
                chk("cnt4_cycle", 32'(n_cycle),   {28'd0, e.mc[3:0]});
                if (e.v.hchk) begin
                    chk("tbl_cpu_en", 32'(cpu_en), 32'(e.v.hen));
                    chk("tbl_state",  32'(state),  32'(e.v.hst));
                end
                if (e.v.hc >= 0) begin
                    chk("tbl_cnt_cycle",  cnt_cycle,  32'(e.v.hc));
                    chk("tbl_cnt4_cycle", 32'(n_cycle), 32'(e.v.hc % 16));
                end
                if (e.v.hj >= 0) chk("tbl_cnt_jump",   cnt_jump,   32'(e.v.hj));
                if (e.v.hb >= 0) chk("tbl_cnt_branch", cnt_branch, 32'(e.v.hb));
                if (e.v.ht >= 0) chk("tbl_cnt_taken",  cnt_taken,  32'(e.v.ht));
            end
        end
    end

    initial begin
        vec_t v;
        rst_n = 1'b1; btn_run = 1'b0; btn_step = 1'b0; btn_pause = 1'b0;
        halt = 1'b0; is_jump = 1'b0; is_branch = 1'b0; branched = 1'b0;
        cnt_clr = 1'b0; div_sel = '0;

        // reset: first cycle unchecked, second checks the reset state
        v = '{default: 0}; v.rst = 1'b1; v.skip = 1'b1;
        v.hc = -1; v.hj = -1; v.hb = -1; v.ht = -1;
        tbl.push_back(v);
        add(0, 0, 0, 0, 0, 1, 0, 3'd0); addc(0, 0, 0, 0);

        // free-running at div_sel=0
        add(B_RUN, 0, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 1, 3'd1);

        // div_sel=3: enable on every fourth cycle
        for (int i = 0; i < 40; i++) begin
            add(0, 0, 3, 0, 0, 0, (i % 4 == 3), 3'd1);
            if (i == 0) addc(10, 0, 0, 0);
        end
        add(0, 0, 3, 0, 0, 0, 0, 3'd1); addc(20, 0, 0, 0);
        add(0, 0, 3, 0, 0, 0, 0, 3'd1);
        add(0, 0, 1, 0, 0, 0, 1, 3'd1);   // presc=2 >= new div_sel=1
        add(0, 0, 1, 0, 0, 0, 0, 3'd1);
        add(0, 0, 1, 0, 0, 0, 1, 3'd1);

        // halt in RUN, then KICK resume
        add(0, 0, 0, 0, 0, 0, 1, 3'd1); addc(22, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 3'd1);
        add(0, 1, 0, 0, 0, 0, 0, 3'd4);
        add(B_RUN, 1, 0, 0, 0, 0, 0, 3'd4); addc(23, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3'd3);
        add(0, 0, 0, 0, 0, 0, 1, 3'd1);
        add(0, 0, 0, 0, 0, 0, 1, 3'd1);
        add(B_PAUSE, 0, 0, 0, 0, 0, 1, 3'd1);
        add(0, 0, 0, 0, 1, 0, 0, 3'd0); addc(27, 0, 0, 0);

        // three single steps, one of them with halt asserted
        add(B_STEP, 0, 0, 0, 0, 0, 0, 3'd0); addc(0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3'd2);
        add(B_STEP, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 1, 3'd2);
        add(B_STEP, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 0, 0, 1, 3'd2);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0); addc(3, 0, 0, 0);
        // step+run together in STOP
        add(B_STEP | B_RUN, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0, 1, 3'd2);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0); addc(4, 0, 0, 0);
        // all buttons together in HALT: pause wins
        add(B_RUN, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 0, 0, 0, 3'd1);
        add(0, 1, 0, 0, 0, 0, 0, 3'd4);
        add(3'b111, 1, 0, 0, 0, 0, 0, 3'd4);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0); addc(4, 0, 0, 0);
        // step out of HALT with halt still high
        add(B_RUN, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 1, 0, 0, 0, 0, 0, 3'd1);
        add(B_STEP, 1, 0, 0, 0, 0, 0, 3'd4);
        add(0, 1, 0, 0, 0, 0, 1, 3'd2);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0); addc(5, 0, 0, 0);

        // statistics: 5 enables, jumps 2, branches 3, taken 1
        add(0, 0, 0, 0, 1, 0, 0, 3'd0);
        add(B_RUN, 0, 0, 0, 0, 0, 0, 3'd0); addc(0, 0, 0, 0);
        add(0, 0, 0, 3'b110, 0, 0, 1, 3'd1);
        add(0, 0, 0, 3'b011, 0, 0, 1, 3'd1);
        add(0, 0, 0, 3'b100, 0, 0, 1, 3'd1);
        add(0, 0, 0, 3'b010, 0, 0, 1, 3'd1);
        add(B_PAUSE, 0, 0, 0, 0, 0, 1, 3'd1);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0); addc(5, 2, 3, 1);
        // clear beats a same-cycle increment; then 16 enables wrap 4-bit count
        add(B_RUN, 0, 0, 0, 0, 0, 0, 3'd0);
        add(0, 0, 0, 3'b111, 1, 0, 1, 3'd1);
        add(0, 0, 0, 0, 0, 0, 1, 3'd1); addc(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) add(0, 0, 0, 0, 0, 0, 1, 3'd1);
        add(B_PAUSE, 0, 0, 0, 0, 0, 1, 3'd1);
        add(0, 0, 0, 0, 0, 0, 0, 3'd0); addc(16, 0, 0, 0);

        // reset mid-RUN at presc=2; run pulses during reset ignored
        add(B_RUN, 0, 3, 0, 0, 0, 0, 3'd0);
        add(0, 0, 3, 0, 0, 0, 0, 3'd1);
        add(0, 0, 3, 0, 0, 0, 0, 3'd1);
        add(B_RUN, 0, 3, 0, 0, 1, 0, 3'd1);
        add(B_RUN, 0, 3, 0, 0, 1, 0, 3'd0); addc(0, 0, 0, 0);
        add(0, 0, 3, 0, 0, 0, 0, 3'd0);
        add(0, 0, 3, 0, 0, 0, 0, 3'd0); addc(0, 0, 0, 0);

        foreach (tbl[i]) apply(tbl[i]);

        // random traffic checked against the model only
        for (int i = 0; i < 400; i++) begin
            v = '{default: 0};
            v.hc = -1; v.hj = -1; v.hb = -1; v.ht = -1;
            v.cmd[0] = ($urandom_range(0, 7) == 0);
            v.cmd[1] = ($urandom_range(0, 9) == 0);
            v.cmd[2] = ($urandom_range(0, 15) == 0);
            v.hlt    = ($urandom_range(0, 5) == 0);
            v.div    = int'($urandom_range(0, 3));
            v.jbt    = 3'($urandom_range(0, 7));
            v.clr    = ($urandom_range(0, 39) == 0);
            v.rst    = ($urandom_range(0, 149) == 0);
            apply(v);
        end

        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_syn_exec_controller
`default_nettype wire
